// File: rtl/display_pkg.sv
// Shared segment encodings for the multiplexed 7-segment display.
// Segment vectors are active-low, bit 0 = a through bit 6 = g.
package display_pkg;

    localparam int SEG_BITS  = 7;
    localparam int BIT_SEG_A = 0;
    localparam int BIT_SEG_B = 1;
    localparam int BIT_SEG_C = 2;
    localparam int BIT_SEG_D = 3;
    localparam int BIT_SEG_E = 4;
    localparam int BIT_SEG_F = 5;
    localparam int BIT_SEG_G = 6;

    localparam logic [SEG_BITS-1:0] SEG_0       = 7'b1000000;
    localparam logic [SEG_BITS-1:0] SEG_1       = 7'b1111001;
    localparam logic [SEG_BITS-1:0] SEG_2       = 7'b0100100;
    localparam logic [SEG_BITS-1:0] SEG_3       = 7'b0110000;
    localparam logic [SEG_BITS-1:0] SEG_4       = 7'b0011001;
    localparam logic [SEG_BITS-1:0] SEG_5       = 7'b0010010;
    localparam logic [SEG_BITS-1:0] SEG_6       = 7'b0000010;
    localparam logic [SEG_BITS-1:0] SEG_7       = 7'b1111000;
    localparam logic [SEG_BITS-1:0] SEG_8       = 7'b0000000;
    localparam logic [SEG_BITS-1:0] SEG_9       = 7'b0010000;
    localparam logic [SEG_BITS-1:0] SEG_A       = 7'b0001000;
    localparam logic [SEG_BITS-1:0] SEG_B       = 7'b0000011;
    localparam logic [SEG_BITS-1:0] SEG_C       = 7'b1000110;
    localparam logic [SEG_BITS-1:0] SEG_D       = 7'b0100001;
    localparam logic [SEG_BITS-1:0] SEG_E       = 7'b0000110;
    localparam logic [SEG_BITS-1:0] SEG_F       = 7'b0001110;
    localparam logic [SEG_BITS-1:0] SEG_APAGADO = 7'b1111111;

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational nibble to active-low 7-segment decoder.
// Values 10..15 show letters only when modo_hex is set; apagar forces blank.
module decodificador_7seg
    import display_pkg::*;
(
    input  logic [3:0]          nibble,
    input  logic                modo_hex,
    input  logic                apagar,
    output logic [SEG_BITS-1:0] segmentos
);

    always_comb begin
        segmentos = SEG_APAGADO;
        if (!apagar) begin
            case (nibble)
                4'h0: segmentos = SEG_0;
                4'h1: segmentos = SEG_1;
                4'h2: segmentos = SEG_2;
                4'h3: segmentos = SEG_3;
                4'h4: segmentos = SEG_4;
                4'h5: segmentos = SEG_5;
                4'h6: segmentos = SEG_6;
                4'h7: segmentos = SEG_7;
                4'h8: segmentos = SEG_8;
                4'h9: segmentos = SEG_9;
                4'hA: segmentos = modo_hex ? SEG_A : SEG_APAGADO;
                4'hB: segmentos = modo_hex ? SEG_B : SEG_APAGADO;
                4'hC: segmentos = modo_hex ? SEG_C : SEG_APAGADO;
                4'hD: segmentos = modo_hex ? SEG_D : SEG_APAGADO;
                4'hE: segmentos = modo_hex ? SEG_E : SEG_APAGADO;
                default: segmentos = modo_hex ? SEG_F : SEG_APAGADO;
            endcase
        end
    end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed 7-segment driver with frame-synchronous value updates.
// Optional leading-zero blanking is enabled by defining DISPLAY_ZERO_BLANK_EN.
module display_mux
    import display_pkg::*;
#(
    parameter int N_DIGITOS     = 4,
    parameter int DIV_VARREDURA = 50000,
    parameter int MODO_HEX      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*N_DIGITOS-1:0] digitos,
    input  logic [N_DIGITOS-1:0]   pontos,
    input  logic                   carregar,
    output logic [6:0]             segmentos,
    output logic                   ponto,
    output logic [N_DIGITOS-1:0]   anodos,
    output logic                   quadro
);

    localparam int PRESC_W = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
    localparam int IDX_W   = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV_VARREDURA - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(N_DIGITOS - 1);

    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [4*N_DIGITOS-1:0] disp_dig_q, disp_dig_d;
    logic [N_DIGITOS-1:0]   disp_pts_q, disp_pts_d;
    logic [4*N_DIGITOS-1:0] pend_dig_q, pend_dig_d;
    logic [N_DIGITOS-1:0]   pend_pts_q, pend_pts_d;
    logic                   pend_flag_q, pend_flag_d;
    logic [6:0]             segmentos_q, segmentos_d;
    logic                   ponto_q, ponto_d;
    logic [N_DIGITOS-1:0]   anodos_q, anodos_d;

    logic       wrap;
    logic       fim_quadro;
    logic [3:0] nibble_sel;
    logic       apagar;
    logic [6:0] seg_dec;

    // Apply happens before the load so a coincident strobe lands in pending.
    always_comb begin
        wrap        = (presc_q == PRESC_MAX);
        fim_quadro  = wrap && (idx_q == IDX_MAX);
        presc_d     = wrap ? '0 : presc_q + PRESC_W'(1);
        idx_d       = idx_q;
        disp_dig_d  = disp_dig_q;
        disp_pts_d  = disp_pts_q;
        pend_dig_d  = pend_dig_q;
        pend_pts_d  = pend_pts_q;
        pend_flag_d = pend_flag_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
        if (fim_quadro && pend_flag_q) begin
            disp_dig_d  = pend_dig_q;
            disp_pts_d  = pend_pts_q;
            pend_flag_d = 1'b0;
        end
        if (carregar) begin
            pend_dig_d  = digitos;
            pend_pts_d  = pontos;
            pend_flag_d = 1'b1;
        end
    end

    assign nibble_sel = disp_dig_q[{idx_q, 2'b00} +: 4];

`ifdef DISPLAY_ZERO_BLANK_EN
    logic [N_DIGITOS-1:0] mascara_apagar;
    logic                 ainda_zero;

    // Blanking runs from the top position down and stops at the first
    // significant nibble or lit point; position 0 always shows.
    always_comb begin
        mascara_apagar = '0;
        ainda_zero     = 1'b1;
        for (int i = N_DIGITOS - 1; i >= 1; i--) begin
            ainda_zero = ainda_zero && (disp_dig_q[4*i +: 4] == 4'h0) && !disp_pts_q[i];
            mascara_apagar[i] = ainda_zero;
        end
    end

    assign apagar = mascara_apagar[idx_q];
`else
    assign apagar = 1'b0;
`endif

    decodificador_7seg u_decodificador (
        .nibble    (nibble_sel),
        .modo_hex  (MODO_HEX != 0),
        .apagar    (apagar),
        .segmentos (seg_dec)
    );

    always_comb begin
        segmentos_d = seg_dec;
        ponto_d     = ~disp_pts_q[idx_q];
        anodos_d    = ~(N_DIGITOS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            disp_dig_q  <= '0;
            disp_pts_q  <= '0;
            pend_dig_q  <= '0;
            pend_pts_q  <= '0;
            pend_flag_q <= 1'b0;
            segmentos_q <= SEG_APAGADO;
            ponto_q     <= 1'b1;
            anodos_q    <= '1;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            disp_dig_q  <= disp_dig_d;
            disp_pts_q  <= disp_pts_d;
            pend_dig_q  <= pend_dig_d;
            pend_pts_q  <= pend_pts_d;
            pend_flag_q <= pend_flag_d;
            segmentos_q <= segmentos_d;
            ponto_q     <= ponto_d;
            anodos_q    <= anodos_d;
        end
    end

    // Held low while rst is asserted even if the prescaler is still at wrap.
    assign quadro    = fim_quadro && !rst;
    assign segmentos = segmentos_q;
    assign ponto     = ponto_q;
    assign anodos    = anodos_q;

endmodule

// File: tb/tb_display_mux.sv
// Scoreboard bench for display_mux: decimal and hex instances share stimulus,
// a cycle-count reference model queues expected outputs for a negedge monitor.
module tb_display_mux;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        carregar = 1'b0;
    logic [15:0] digitos  = 16'h0;
    logic [3:0]  pontos   = 4'h0;

    logic [6:0] seg_dec, seg_hex;
    logic       ponto_dec, ponto_hex;
    logic [3:0] an_dec, an_hex;
    logic       q_dec, q_hex;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg_dec;
        logic [6:0] seg_hex;
        logic       pt;
        logic       frame_end;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int          n_ciclos  = 0;
    logic [15:0] m_disp    = 16'h0;
    logic [3:0]  m_disp_pt = 4'h0;
    logic [15:0] m_pend    = 16'h0;
    logic [3:0]  m_pend_pt = 4'h0;
    logic        m_flag    = 1'b0;

    always #5 clk = ~clk;

    display_mux #(.N_DIGITOS(N), .DIV_VARREDURA(DIV), .MODO_HEX(0)) dut_dec (
        .clk(clk), .rst(rst), .digitos(digitos), .pontos(pontos), .carregar(carregar),
        .segmentos(seg_dec), .ponto(ponto_dec), .anodos(an_dec), .quadro(q_dec)
    );

    display_mux #(.N_DIGITOS(N), .DIV_VARREDURA(DIV), .MODO_HEX(1)) dut_hex (
        .clk(clk), .rst(rst), .digitos(digitos), .pontos(pontos), .carregar(carregar),
        .segmentos(seg_hex), .ponto(ponto_hex), .anodos(an_hex), .quadro(q_hex)
    );

    function automatic logic [6:0] decode(input logic [3:0] v, input logic hex);
        case (v)
            4'd0:  return 7'b1000000;
            4'd1:  return 7'b1111001;
            4'd2:  return 7'b0100100;
            4'd3:  return 7'b0110000;
            4'd4:  return 7'b0011001;
            4'd5:  return 7'b0010010;
            4'd6:  return 7'b0000010;
            4'd7:  return 7'b1111000;
            4'd8:  return 7'b0000000;
            4'd9:  return 7'b0010000;
            4'd10: return hex ? 7'b0001000 : 7'b1111111;
            4'd11: return hex ? 7'b0000011 : 7'b1111111;
            4'd12: return hex ? 7'b1000110 : 7'b1111111;
            4'd13: return hex ? 7'b0100001 : 7'b1111111;
            4'd14: return hex ? 7'b0000110 : 7'b1111111;
            default: return hex ? 7'b0001110 : 7'b1111111;
        endcase
    endfunction

    // Position p is blanked when it and every higher position are zero with no point.
    function automatic logic is_blank(input logic [15:0] d, input logic [3:0] p, input int pos);
`ifdef DISPLAY_ZERO_BLANK_EN
        if (pos == 0) return 1'b0;
        for (int k = pos; k < N; k++) begin
            if (((d >> (4 * k)) & 16'hF) != 16'h0 || p[k]) return 1'b0;
        end
        return 1'b1;
`else
        return (d == 16'hFFFF) && (p == 4'hF) && (pos < 0);
`endif
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int   idx;
        logic [3:0] nib;
        if (rst) begin
            n_ciclos  = 0;
            m_disp    = 16'h0;
            m_disp_pt = 4'h0;
            m_pend    = 16'h0;
            m_pend_pt = 4'h0;
            m_flag    = 1'b0;
            e.an      = 4'b1111;
            e.seg_dec = 7'b1111111;
            e.seg_hex = 7'b1111111;
            e.pt      = 1'b1;
        end else begin
            idx = (n_ciclos / DIV) % N;
            nib = 4'((m_disp >> (4 * idx)) & 16'hF);
            e.an = ~(4'b0001 << idx);
            if (is_blank(m_disp, m_disp_pt, idx)) begin
                e.seg_dec = 7'b1111111;
                e.seg_hex = 7'b1111111;
            end else begin
                e.seg_dec = decode(nib, 1'b0);
                e.seg_hex = decode(nib, 1'b1);
            end
            e.pt = ~m_disp_pt[idx];
            if ((n_ciclos % FRAME) == FRAME - 1 && m_flag) begin
                m_disp    = m_pend;
                m_disp_pt = m_pend_pt;
                m_flag    = 1'b0;
            end
            if (carregar) begin
                m_pend    = digitos;
                m_pend_pt = pontos;
                m_flag    = 1'b1;
            end
            n_ciclos++;
        end
        e.frame_end = ((n_ciclos % FRAME) == FRAME - 1);
        exp_q.push_back(e);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("anodos_dec", 32'(an_dec), 32'(e.an));
            checkOutput("anodos_hex", 32'(an_hex), 32'(e.an));
            checkOutput("segmentos_dec", 32'(seg_dec), 32'(e.seg_dec));
            checkOutput("segmentos_hex", 32'(seg_hex), 32'(e.seg_hex));
            checkOutput("ponto_dec", 32'(ponto_dec), 32'(e.pt));
            checkOutput("ponto_hex", 32'(ponto_hex), 32'(e.pt));
            checkOutput("quadro_dec", 32'(q_dec), 32'(e.frame_end && !rst));
            checkOutput("quadro_hex", 32'(q_hex), 32'(e.frame_end && !rst));
        end
    end

    // Inputs are set just after an edge and held for exactly the following edge.
    task automatic applyStimulus(input logic r, input logic c, input logic [15:0] d, input logic [3:0] p);
        rst      = r;
        carregar = c;
        digitos  = d;
        pontos   = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, digitos, pontos);
    endtask

    task automatic alignTo(input int phase);
        for (int i = 0; i < FRAME && (n_ciclos % FRAME) != phase; i++) idle(1);
    endtask

    task automatic loadAndShow(input logic [15:0] d, input logic [3:0] p);
        alignTo(2);
        applyStimulus(1'b0, 1'b1, d, p);
        idle(2 * FRAME + 2);
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  rp;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        idle(DIV + 1);
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'h0);
        idle(2 * FRAME + 2);

        loadAndShow(16'hABCD, 4'b0101);
        loadAndShow(16'hEF9A, 4'b0000);
        loadAndShow(16'h0070, 4'b0000);
        loadAndShow(16'h0000, 4'b0000);
        loadAndShow(16'h0005, 4'b0100);

        alignTo(0);
        applyStimulus(1'b0, 1'b1, 16'h1111, 4'h0);
        alignTo(FRAME - 1);
        applyStimulus(1'b0, 1'b1, 16'h5555, 4'h0);
        idle(2 * FRAME + 2);

        alignTo(5);
        applyStimulus(1'b0, 1'b1, 16'h9876, 4'b0010);
        idle(3);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        idle(2 * FRAME + 2);

        for (int i = 0; i < 400; i++) begin
            rd = 16'h0;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 1) == 1) rd[4*k +: 4] = 4'($urandom_range(0, 15));
            end
            rp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0), rd, rp);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
